// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and memory-stage FSM state type
package mips_pkg;
    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    typedef enum logic [1:0] {IDLE, WAIT, LAST} state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: word-addressed single-port data RAM, sync write, read-before-write
module dmem_ram
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    // combinational read returns the old word during a same-cycle write
    assign rdata = mem[addr];
    // array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/mem_stage_responder.sv
// mem_stage_responder: MEM stage with wait-stated data RAM and MEM/WB register
module mem_stage_responder
    import mips_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [WORD_W-1:0] ALUOutM,
    input  logic [WORD_W-1:0] WriteDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [WORD_W-1:0] ReadDataW,
    output logic [WORD_W-1:0] ALUOutW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic              AddrErr
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    state_t state, nstate;
    logic [3:0] cnt, ncnt;
    logic access, stall, complete;
    logic [WORD_W-1:0] rdata;
    assign access   = MemWriteM | MemtoRegM;
    assign stall    = access && ((state == IDLE && WS != 4'd0) || state == WAIT);
    assign complete = access && (state == LAST || (state == IDLE && WS == 4'd0));
    assign StallM   = RST & stall;
    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (complete & MemWriteM),
        .addr  (ALUOutM[ADDR_W+1:2]),
        .wdata (WriteDataM),
        .rdata (rdata)
    );
    // state and wait counter registers
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
        end
    end
    // next state: count down wait states, complete the access in LAST
    always_comb begin
        nstate = state;
        ncnt   = cnt;
        case (state)
            IDLE: if (access && WS != 4'd0) begin
                ncnt   = WS - 4'd1;
                nstate = (WS == 4'd1) ? LAST : WAIT;
            end
            WAIT: begin
                ncnt   = access ? cnt - 4'd1 : 4'd0;
                nstate = !access ? IDLE : (cnt <= 4'd1) ? LAST : WAIT;
            end
            LAST: begin
                ncnt   = 4'd0;
                nstate = IDLE;
            end
            default: begin
                ncnt   = 4'd0;
                nstate = IDLE;
            end
        endcase
    end
    // MEM/WB register: bubble while stalled, otherwise load M fields
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            AddrErr   <= 1'b0;
        end else begin
            RegWriteW <= stall ? 1'b0 : RegWriteM;
            MemtoRegW <= stall ? 1'b0 : MemtoRegM;
            ReadDataW <= (complete && MemtoRegM) ? rdata : '0;
            ALUOutW   <= stall ? '0 : ALUOutM;
            WriteRegW <= stall ? '0 : WriteRegM;
            AddrErr   <= AddrErr | (complete && ALUOutM[1:0] != 2'b00);
        end
    end
endmodule
